// File: rtl/alu_seq_exec_if.sv
// rtl/alu_seq_exec_if.sv - handshake bundle between issue logic and the sequential ALU
//
// Purpose: groups the request side (in_valid/in_ready, opcode, operands) and the
// response side (out_valid/out_ready, result, zero, busy) of alu_seq_exec.
// Modports:
//   master - issuing/consuming side: drives in_valid, alu_control, src_a, src_b, out_ready
//   slave  - the ALU: drives in_ready, out_valid, result, zero, busy
interface alu_seq_exec_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with single-cycle arithmetic and serial shifts
//
// Purpose: ADD/SUB/XOR/OR/AND/SLT/SLTU/pass-through finish in the accept cycle;
// SLL/SRL/SRA iterate one bit per cycle. Result is held in DONE until taken.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - alu_seq_exec_if.slave: in_valid/in_ready, alu_control, src_a, src_b,
//            out_valid/out_ready, result, zero, busy
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_exec_if.slave bus
);

  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_SHIFTL           = 4'd1;
  localparam logic [3:0] ALU_ADD              = 4'd2;
  localparam logic [3:0] ALU_SUB              = 4'd3;
  localparam logic [3:0] ALU_XOR              = 4'd4;
  localparam logic [3:0] ALU_OR               = 4'd5;
  localparam logic [3:0] ALU_AND              = 4'd6;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd7;
  localparam logic [3:0] ALU_SHIFTR           = 4'd8;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd10;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SK_LL = 2'd0,
    SK_RL = 2'd1,
    SK_RA = 2'd2
  } shift_kind_t;

  state_t             state_q, state_d;
  shift_kind_t        shk_q, shk_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shifted;
  logic               is_shift;
  shift_kind_t        new_shk;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = bus.src_b[SHAMT_W-1:0];

  // Single-cycle datapath; unknown codes fall through to src_b pass-through.
  always_comb begin
    alu_out = bus.src_b;
    case (bus.alu_control)
      ALU_ADD:              alu_out = bus.src_a + bus.src_b;
      ALU_SUB:              alu_out = bus.src_a - bus.src_b;
      ALU_XOR:              alu_out = bus.src_a ^ bus.src_b;
      ALU_OR:               alu_out = bus.src_a | bus.src_b;
      ALU_AND:              alu_out = bus.src_a & bus.src_b;
      ALU_LESS_THAN_SIGNED: alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      ALU_LESS_THAN:        alu_out = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
      ALU_NONE:             alu_out = bus.src_b;
      default:              alu_out = bus.src_b;
    endcase
  end

  always_comb begin
    is_shift = 1'b1;
    new_shk  = SK_LL;
    case (bus.alu_control)
      ALU_SHIFTL:       new_shk = SK_LL;
      ALU_SHIFTR:       new_shk = SK_RL;
      ALU_SHIFTR_ARITH: new_shk = SK_RA;
      default:          is_shift = 1'b0;
    endcase
  end

  // One-bit step of the serial shifter, using the kind latched at accept.
  always_comb begin
    shifted = acc_q;
    case (shk_q)
      SK_LL:   shifted = {acc_q[WIDTH-2:0], 1'b0};
      SK_RL:   shifted = {1'b0, acc_q[WIDTH-1:1]};
      SK_RA:   shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shk_d    = shk_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_shift) begin
            shk_d   = new_shk;
            acc_d   = bus.src_a;
            count_d = shamt;
            if (shamt == '0) begin
              result_d = bus.src_a;
              zero_d   = (bus.src_a == '0);
              state_d  = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            // Single-cycle ops resolve in the accept cycle and go straight to DONE.
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d   = shifted;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shk_q    <= SK_LL;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shk_q    <= shk_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // in_ready also gated by rst_n so nothing is accepted while reset is held.
  assign bus.in_ready  = (state_q == ST_IDLE) && rst_n;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

  localparam logic [3:0] ALU_NONE             = 4'd0;
  localparam logic [3:0] ALU_SHIFTL           = 4'd1;
  localparam logic [3:0] ALU_ADD              = 4'd2;
  localparam logic [3:0] ALU_SUB              = 4'd3;
  localparam logic [3:0] ALU_XOR              = 4'd4;
  localparam logic [3:0] ALU_OR               = 4'd5;
  localparam logic [3:0] ALU_AND              = 4'd6;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd7;
  localparam logic [3:0] ALU_SHIFTR           = 4'd8;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd9;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd10;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    int          exp_lat;
    int          stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_exec_if #(.WIDTH(32)) bus ();

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the opcode meaning.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int amt;
    amt = int'(b % 32);
    lat = 1;
    case (op)
      ALU_ADD:              res = a + b;
      ALU_SUB:              res = a - b;
      ALU_XOR:              res = a ^ b;
      ALU_OR:               res = a | b;
      ALU_AND:              res = a & b;
      ALU_LESS_THAN_SIGNED: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_LESS_THAN:        res = (a < b) ? 32'd1 : 32'd0;
      ALU_SHIFTL:       begin res = a << amt;                      lat = (amt == 0) ? 1 : amt + 1; end
      ALU_SHIFTR:       begin res = a >> amt;                      lat = (amt == 0) ? 1 : amt + 1; end
      ALU_SHIFTR_ARITH: begin res = $unsigned($signed(a) >>> amt); lat = (amt == 0) ? 1 : amt + 1; end
      default:              res = b;
    endcase
  endtask

  // Issue one op, wait for its result with operands scrambled in flight,
  // optionally hold off out_ready, then release and confirm return to idle.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                       input int exp_lat, input int stall);
    int lat;
    int busy_cyc;
    chk({name, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.out_ready   = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    busy_cyc = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_cyc++;
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.alu_control = 4'($urandom);
      bus.src_a       = $urandom;
      bus.src_b       = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, bus.result, exp_res);
    chk({name, " zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
    chk({name, " shift busy cycles"}, busy_cyc, exp_lat - 1);
    chk({name, " in_ready done"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({name, " stall out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({name, " stall result"}, bus.result, exp_res);
      chk({name, " stall in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, " back idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rres;
    logic [3:0]  rop;
    int          rlat;
    int          seen;

    vecs[0] = '{ALU_ADD,              32'd5,          32'd7,          32'd12,         1'b0, 1,  0};
    vecs[1] = '{ALU_XOR,              32'h1234_5678,  32'h1234_5678,  32'h0,          1'b1, 1,  0};
    vecs[2] = '{ALU_SUB,              32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1,  1};
    vecs[3] = '{ALU_SHIFTR_ARITH,     32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 5,  0};
    vecs[4] = '{ALU_SHIFTR,           32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 5,  2};
    vecs[5] = '{ALU_SHIFTL,           32'd1,          32'd31,         32'h8000_0000,  1'b0, 32, 0};
    vecs[6] = '{ALU_SHIFTL,           32'hDEAD_BEEF,  32'h20,         32'hDEAD_BEEF,  1'b0, 1,  0};
    vecs[7] = '{ALU_LESS_THAN_SIGNED, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1,  0};
    vecs[8] = '{ALU_LESS_THAN,        32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1,  3};
    vecs[9] = '{4'hF,                 32'd1,          32'h0000_ABCD,  32'h0000_ABCD,  1'b0, 1,  0};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = ALU_NONE;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset zero", {31'd0, bus.zero}, 32'd1);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_lat, vecs[i].stall);
    end

    // Reset in the middle of a 20-bit left shift.
    bus.in_valid    = 1'b1;
    bus.alu_control = ALU_SHIFTL;
    bus.src_a       = 32'h0000_0003;
    bus.src_b       = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort busy before reset", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready in reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort result", bus.result, 32'd0);
    chk("abort zero", {31'd0, bus.zero}, 32'd1);
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) seen++;
    end
    chk("abort no output", seen, 0);
    do_op("add after abort", ALU_ADD, 32'd100, 32'hFFFF_FFFF, 32'd99, 1'b0, 1, 0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? ra : $urandom;
      if (rop == ALU_SHIFTL || rop == ALU_SHIFTR || rop == ALU_SHIFTR_ARITH)
        rb = {$urandom_range(0, 7), 24'h0, 3'h0, 5'($urandom_range(0, 12))};
      model(rop, ra, rb, rres, rlat);
      do_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, rres, (rres == 32'd0),
            rlat, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
